// File: rtl/mon_prefetch.sv
// Sequential read-prefetch buffer in front of the monitor Wishbone slave; hits ack next cycle, misses/writes go to the slave.
// Optional hit/miss statistics counters are enabled by defining MON_PREFETCH_STATS_EN.
module mon_prefetch #(
    parameter int DEPTH       = 4,
    parameter int WINDOW_BITS = 13
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic        flush,
    input  logic [31:0] s_adr_i,
    input  logic [31:0] s_dat_i,
    input  logic [3:0]  s_sel_i,
    input  logic        s_we_i,
    input  logic        s_stb_i,
    input  logic        s_cyc_i,
    output logic [31:0] s_dat_o,
    output logic        s_ack_o,
    output logic [31:0] m_adr_o,
    output logic [31:0] m_dat_o,
    output logic [3:0]  m_sel_o,
    output logic        m_we_o,
    output logic        m_stb_o,
    output logic        m_cyc_o,
    input  logic [31:0] m_dat_i,
    input  logic        m_ack_i
`ifdef MON_PREFETCH_STATS_EN
    ,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count
`endif
);

    localparam int HW = $clog2(DEPTH);
    localparam logic [HW:0] FULL = (HW+1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, PREF, MISS, WR} state_t;

    state_t        state;
    logic [31:0]   mem [DEPTH];
    logic [HW-1:0] head;
    logic [HW:0]   cnt;
    logic [29:0]   base;
    logic          pf_kill;

    logic [29:0]   s_word;
    logic [29:0]   off;
    logic          dem, rd_req, wr_req, hit;
    logic          pf_ack, pf_match, pf_keep, serve, miss_go, pf_ok;
    logic [HW:0]   k;
    logic [HW-1:0] rd_slot, wr_slot;
    logic [30:0]   pf_sum;
    logic          unused_adr;

    assign unused_adr = ^s_adr_i[1:0];

    assign s_word  = s_adr_i[31:2];
    assign off     = s_word - base;
    assign dem     = s_stb_i & s_cyc_i & ~s_ack_o & ((state == IDLE) | (state == PREF));
    assign rd_req  = dem & ~s_we_i;
    assign wr_req  = dem & s_we_i;
    assign hit     = rd_req & (off < 30'(cnt));

    // A prefetch that lands on the word the CPU is waiting for is served directly.
    assign pf_ack   = (state == PREF) & m_ack_i;
    assign pf_match = pf_ack & ~pf_kill & rd_req & ~hit & (s_word == m_adr_o[31:2]);
    assign serve    = hit | pf_match;
    assign pf_keep  = pf_ack & ~pf_kill & (~dem | serve);
    assign k        = pf_match ? cnt : off[HW:0];
    assign rd_slot  = head + off[HW-1:0];
    assign wr_slot  = head + cnt[HW-1:0];
    assign miss_go  = (state == IDLE) & rd_req & ~hit;

    // Carry out of the 30-bit sum means the next word would wrap past the top of memory.
    assign pf_sum = {1'b0, base} + 31'(cnt);
    assign pf_ok  = (state == IDLE) & ~dem & ~flush & (cnt != '0) & (cnt < FULL) & ~pf_sum[30]
                  & (pf_sum[29:WINDOW_BITS-2] == base[29:WINDOW_BITS-2]);

    always_ff @(posedge sys_clk) begin
        if (pf_keep)
            mem[wr_slot] <= m_dat_i;
        else if ((state == MISS) && m_ack_i)
            mem[0] <= m_dat_i;
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state   <= IDLE;
            head    <= '0;
            cnt     <= '0;
            base    <= '0;
            pf_kill <= 1'b0;
            s_dat_o <= '0;
            s_ack_o <= 1'b0;
            m_adr_o <= '0;
            m_dat_o <= '0;
            m_sel_o <= '0;
            m_we_o  <= 1'b0;
            m_stb_o <= 1'b0;
            m_cyc_o <= 1'b0;
        end else begin
            s_ack_o <= 1'b0;

            if (serve) begin
                s_ack_o <= 1'b1;
                s_dat_o <= pf_match ? m_dat_i : mem[rd_slot];
                head    <= head + k[HW-1:0];
                base    <= base + 30'(k);
            end

            if (flush || wr_req)
                cnt <= '0;
            else if ((state == MISS) && m_ack_i)
                cnt <= (HW+1)'(1);
            else
                cnt <= cnt - (serve ? k : '0) + (HW+1)'(pf_keep);

            case (state)
                IDLE: begin
                    if (wr_req) begin
                        m_stb_o <= 1'b1;
                        m_cyc_o <= 1'b1;
                        m_we_o  <= 1'b1;
                        m_adr_o <= {s_adr_i[31:2], 2'b00};
                        m_dat_o <= s_dat_i;
                        m_sel_o <= s_sel_i;
                        state   <= WR;
                    end else if (miss_go) begin
                        m_stb_o <= 1'b1;
                        m_cyc_o <= 1'b1;
                        m_we_o  <= 1'b0;
                        m_adr_o <= {s_adr_i[31:2], 2'b00};
                        m_sel_o <= 4'hF;
                        state   <= MISS;
                    end else if (pf_ok) begin
                        m_stb_o <= 1'b1;
                        m_cyc_o <= 1'b1;
                        m_we_o  <= 1'b0;
                        m_adr_o <= {pf_sum[29:0], 2'b00};
                        m_sel_o <= 4'hF;
                        pf_kill <= 1'b0;
                        state   <= PREF;
                    end
                end
                PREF: begin
                    if (m_ack_i) begin
                        m_stb_o <= 1'b0;
                        m_cyc_o <= 1'b0;
                        state   <= IDLE;
                    end else if (flush || wr_req) begin
                        pf_kill <= 1'b1;
                    end
                end
                MISS: begin
                    if (m_ack_i) begin
                        m_stb_o <= 1'b0;
                        m_cyc_o <= 1'b0;
                        s_ack_o <= 1'b1;
                        s_dat_o <= m_dat_i;
                        head    <= '0;
                        base    <= m_adr_o[31:2];
                        state   <= IDLE;
                    end
                end
                WR: begin
                    if (m_ack_i) begin
                        m_stb_o <= 1'b0;
                        m_cyc_o <= 1'b0;
                        m_we_o  <= 1'b0;
                        s_ack_o <= 1'b1;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef MON_PREFETCH_STATS_EN
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else if (flush) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            if (serve && (hit_count != 32'hFFFF_FFFF))
                hit_count <= hit_count + 32'd1;
            if (miss_go && (miss_count != 32'hFFFF_FFFF))
                miss_count <= miss_count + 32'd1;
        end
    end
`endif

endmodule
